// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux_arbiter_pkg;

  localparam int N_REQ         = 4;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit found searching ptr, ptr+1, ... modulo N_REQ.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_arbiter_fourto1mux.sv
// Plain 4:1 data multiplexer used as the arbiter data path.
module fourto1mux #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_data
);

  // Select one of four inputs by index.
  always_comb begin
    case (i_sel)
      2'd0:    o_data = i_a;
      2'd1:    o_data = i_b;
      2'd2:    o_data = i_c;
      2'd3:    o_data = i_d;
      default: o_data = i_a;
    endcase
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin 4-way arbiter driving a 4:1 data mux, one idle cycle between grants.
// Optional per-grant burst limit enabled by defining BURST_LIMIT_EN.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);

  generate
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("mux_arbiter: MAX_BURST must be in 1..15");
    end
  endgenerate

  arb_state_e r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [1:0] w_pick;
  logic       w_owner_req;
  logic       w_release;

  assign w_pick      = rr_pick(req, r_ptr);
  assign w_owner_req = req[r_sel];

`ifdef BURST_LIMIT_EN
  logic [3:0] r_beat_cnt;
  logic       w_beat;

  assign w_beat    = out_valid & out_ready;
  // The beat that reaches MAX_BURST ends the grant just like a dropped request.
  assign w_release = !w_owner_req || (w_beat && (r_beat_cnt == 4'(MAX_BURST - 1)));

  // Beats taken by the current owner; cleared whenever the grant ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= 4'd0;
    end else if (r_state == GRANT && w_release) begin
      r_beat_cnt <= 4'd0;
    end else if (r_state == GRANT && w_beat) begin
      r_beat_cnt <= r_beat_cnt + 4'd1;
    end else begin
      r_beat_cnt <= r_beat_cnt;
    end
  end
`else
  logic w_unused_ready;

  assign w_unused_ready = out_ready;
  assign w_release      = !w_owner_req;
`endif

  // Arbitration FSM; sel survives release so out_data keeps the last owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state <= GRANT;
            r_sel   <= w_pick;
            r_gnt   <= 4'b0001 << w_pick;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_ptr   <= r_sel + 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state == GRANT);
  assign out_valid = |(r_gnt & req);

  fourto1mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_sel  (r_sel),
    .i_a    (in_a),
    .i_b    (in_b),
    .i_c    (in_c),
    .i_d    (in_d),
    .o_data (out_data)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (default or BURST_LIMIT_EN build).
module tb_mux_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] in_a, in_b, in_c, in_d;
  logic        out_ready;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  mux_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_ready(out_ready), .gnt(gnt), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    out_ready = 1'b1;
    do_reset();
    n_cmp++;
    if ({gnt, sel, busy, out_valid} !== 8'b0000_00_0_0) begin
      n_mis++;
      $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b vld=%b want 0000/0/0/0", gnt, sel, busy, out_valid);
    end
    n_cmp++;
    if (out_data !== 32'hA0) begin
      n_mis++;
      $display("FAIL reset_data: got %h want a0", out_data);
    end
  endtask

  task automatic test_single_grant;
    do_reset();
    req = 4'b0100;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, sel, out_valid, busy} !== 8'b0100_10_1_1 || out_data !== 32'hA2) begin
      n_mis++;
      $display("FAIL single_grant: got gnt=%b sel=%0d vld=%b busy=%b data=%h want 0100/2/1/1/a2", gnt, sel, out_valid, busy, out_data);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0000_10_0) begin
      n_mis++;
      $display("FAIL single_release: got gnt=%b sel=%0d busy=%b want 0000/2/0", gnt, sel, busy);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b1000_11) begin
      n_mis++;
      $display("FAIL search_from_3: got gnt=%b sel=%0d want 1000/3", gnt, sel);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    out_ready = 1'b1;
    req = 4'b0100;
    tick();
    req = 4'b1001;
    tick();
    n_cmp++;
    if ({gnt, busy} !== 5'b0000_0) begin
      n_mis++;
      $display("FAIL wrap_idle_gap: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b1000_11 || out_data !== 32'hA3) begin
      n_mis++;
      $display("FAIL wrap_first: got gnt=%b sel=%0d data=%h want 1000/3/a3", gnt, sel, out_data);
    end
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_mis++;
      $display("FAIL wrap_release3: got gnt=%b want 0000", gnt);
    end
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b0001_00 || out_data !== 32'hA0) begin
      n_mis++;
      $display("FAIL wrap_second: got gnt=%b sel=%0d data=%h want 0001/0/a0", gnt, sel, out_data);
    end
  endtask

  task automatic test_stall_hold;
    do_reset();
    out_ready = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({gnt, sel, out_valid} !== 7'b0010_01_1 || out_data !== 32'hA1) begin
        n_mis++;
        $display("FAIL stall_hold[%0d]: got gnt=%b sel=%0d vld=%b data=%h want 0010/1/1/a1", i, gnt, sel, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
`ifdef BURST_LIMIT_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_mis++;
        $display("FAIL stall_no_count[%0d]: got gnt=%b want 0010", i, gnt);
      end
      tick();
    end
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_mis++;
      $display("FAIL stall_burst_end: got gnt=%b want 0000", gnt);
    end
`else
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_mis++;
      $display("FAIL stall_resume: got gnt=%b want 0010", gnt);
    end
`endif
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    out_ready = 1'b1;
    req = 4'b0100;
    tick();
    req = 4'b1111;
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, sel, busy, out_valid} !== 8'b0000_00_0_0 || out_data !== 32'hA0) begin
      n_mis++;
      $display("FAIL reset_mid_grant: got gnt=%b sel=%0d busy=%b vld=%b data=%h want 0000/0/0/0/a0", gnt, sel, busy, out_valid, out_data);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b0001_00) begin
      n_mis++;
      $display("FAIL reset_ptr_cleared: got gnt=%b sel=%0d want 0001/0", gnt, sel);
    end
  endtask

`ifdef BURST_LIMIT_EN
  task automatic test_back_to_back;
    int owners[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    tick();
    for (int o = 0; o < 5; o++) begin
      for (int b = 0; b < 4; b++) begin
        n_cmp++;
        if (gnt !== (4'b0001 << owners[o]) || out_data !== (32'hA0 + 32'(owners[o]))) begin
          n_mis++;
          $display("FAIL burst_owner[%0d.%0d]: got gnt=%b data=%h want owner %0d", o, b, gnt, out_data, owners[o]);
        end
        tick();
      end
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_mis++;
        $display("FAIL burst_gap[%0d]: got gnt=%b want 0000", o, gnt);
      end
      tick();
    end
  endtask
`else
  task automatic test_back_to_back;
    int beats;
    do_reset();
    req = 4'b0001;
    out_ready = 1'b1;
    tick();
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && out_data === 32'hA0 && gnt === 4'b0001) beats++;
      tick();
    end
    n_cmp++;
    if (beats !== 10) begin
      n_mis++;
      $display("FAIL unlimited_beats: got %0d beats want 10", beats);
    end
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_mis++;
      $display("FAIL unlimited_no_release: got gnt=%b want 0001", gnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    in_a = 32'hA0;
    in_b = 32'hA1;
    in_c = 32'hA2;
    in_d = 32'hA3;
    test_reset();
    test_single_grant();
    test_wrap();
    test_stall_hold();
    test_reset_mid_grant();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
